// File: rtl/intpol2_d4_ctrl_fsm.sv
// Control FSM for the intpol2_D4 quadratic-interpolation datapath: window loading,
// per-segment coefficient setup and two-phase multiply per output point with backpressure.
module intpol2_d4_ctrl_fsm #(
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] l_factor,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 Ld_M0,
    output logic                 Ld_M1,
    output logic                 Ld_M2,
    output logic                 en_stream,
    output logic                 op_1,
    output logic                 clear,
    output logic                 en_sum,
    output logic [1:0]           sel_xi2,
    output logic                 sel_mult,
    output logic                 Ld_p1_xi,
    output logic                 Ld_data
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_LOAD2,
        S_COEF,
        S_CALC1,
        S_CALC2,
        S_NEXT,
        S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] i_q;
    logic [CNT_WIDTH-1:0] l_q;
    logic                 last_seen_q;
    logic                 out_valid_q;
    logic                 err_q;

    logic slot_free;
    logic last_pt;

    // Output slot is free if empty or being drained on this edge.
    assign slot_free = ~out_valid_q | out_ready;
    assign last_pt   = (i_q == (l_q - CNT_ONE));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD0;
            end
            S_LOAD0: begin
                if (in_valid) state_d = in_last ? S_FIN : S_LOAD1;
            end
            S_LOAD1: begin
                if (in_valid) state_d = in_last ? S_FIN : S_LOAD2;
            end
            S_LOAD2: begin
                if (in_valid) state_d = S_COEF;
            end
            S_COEF: begin
                state_d = S_CALC1;
            end
            S_CALC1: begin
                state_d = S_CALC2;
            end
            S_CALC2: begin
                if (slot_free) begin
                    if (!last_pt)         state_d = S_CALC1;
                    else if (last_seen_q) state_d = S_FIN;
                    else                  state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (in_valid) state_d = S_COEF;
            end
            S_FIN: begin
                if (!out_valid_q) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        in_ready  = 1'b0;
        Ld_M0     = 1'b0;
        Ld_M1     = 1'b0;
        Ld_M2     = 1'b0;
        en_stream = 1'b0;
        op_1      = 1'b0;
        clear     = 1'b0;
        en_sum    = 1'b0;
        sel_xi2   = 2'b00;
        sel_mult  = 1'b0;
        Ld_p1_xi  = 1'b0;
        Ld_data   = 1'b0;
        case (state_q)
            S_LOAD0: begin
                in_ready = 1'b1;
                Ld_M0    = in_valid;
            end
            S_LOAD1: begin
                in_ready = 1'b1;
                Ld_M1    = in_valid;
            end
            S_LOAD2: begin
                in_ready = 1'b1;
                Ld_M2    = in_valid;
            end
            S_COEF: begin
                op_1  = 1'b1;
                clear = 1'b1;
            end
            S_CALC1: begin
                Ld_p1_xi = 1'b1;
                if (i_q == '0)         sel_xi2 = 2'b00;
                else if (i_q == CNT_ONE) sel_xi2 = 2'b01;
                else                   sel_xi2 = 2'b10;
            end
            S_CALC2: begin
                sel_mult = 1'b1;
                Ld_data  = slot_free;
                en_sum   = slot_free;
                if (i_q == '0)         sel_xi2 = 2'b00;
                else if (i_q == CNT_ONE) sel_xi2 = 2'b01;
                else                   sel_xi2 = 2'b10;
            end
            S_NEXT: begin
                in_ready  = 1'b1;
                en_stream = in_valid;
            end
            S_FIN: begin
                done = ~out_valid_q;
            end
            default: begin
            end
        endcase
    end

    // Run bookkeeping: point counter, segment length, end-of-stream and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q         <= '0;
            l_q         <= '0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        l_q         <= (l_factor == '0) ? CNT_ONE : l_factor;
                        err_q       <= 1'b0;
                        last_seen_q <= 1'b0;
                    end
                end
                S_LOAD0, S_LOAD1: begin
                    if (in_valid && in_last) err_q <= 1'b1;
                end
                S_LOAD2, S_NEXT: begin
                    if (in_valid) last_seen_q <= in_last;
                end
                S_COEF: begin
                    i_q <= '0;
                end
                S_CALC2: begin
                    if (slot_free && !last_pt) i_q <= i_q + CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // A load on the same edge as a consume keeps the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else if (Ld_data) begin
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: doc/intpol2_d4_ctrl_fsm.md
Name: intpol2_D4_ctrl_fsm

Overview:
Control FSM that sequences the intpol2_D4 quadratic-interpolation datapath. It accepts a stream of input samples over a valid/ready handshake and loads the M0/M1/M2 window. For each window it computes p1/p2 once, then runs L output points, each in a two-phase multiply (p1*xi, then p2*xi^2). It also holds back result generation when the downstream consumer stalls.

Parameters:
CNT_WIDTH, 6, width of interpolation-factor input and internal point counter i.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse in IDLE; begins a run and latches l_factor
l_factor  in  CNT_WIDTH  output points per segment L; 0 treated as 1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
err  out  1  registered; set with done if the stream ended before 3 samples; cleared on start
in_valid  in  1  upstream sample valid (sample is on datapath data_to_process)
in_last  in  1  marks the final sample of the stream; qualified by in_valid&in_ready
in_ready  out  1  controller accepts a sample this cycle
out_valid  out  1  datapath data_out holds an unconsumed result
out_ready  in  1  downstream accepts data_out
Ld_M0, Ld_M1, Ld_M2  out  1 each  window register loads
en_stream  out  1  shift window m0<-m1<-m2<-new sample
op_1  out  1  register p1/p2 from the current window
clear  out  1  zero the xi and xi^2 generators
en_sum  out  1  advance xi and xi^2 by one step
sel_xi2  out  2  xi^2 generator mode: 00 i=0, 01 i=1, 10 i>=2
sel_mult  out  1  0: shared multiplier computes p1*xi; 1: computes p2*xi^2
Ld_p1_xi  out  1  capture p1*xi
Ld_data  out  1  capture y into data_out

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, i=0, last_seen=0. All outputs are 0, including out_valid, err and done. rst mid-run aborts immediately: no done pulse and no further strobes.
- All strobes below are Moore/Mealy combinational from registered state. Default value of every strobe is 0.
- IDLE: on start, latch L=max(l_factor,1), clear err, go to LOAD0.
- LOAD0/LOAD1/LOAD2: in_ready=1. When in_valid=1, assert Ld_M0/Ld_M1/Ld_M2 respectively and advance. If in_valid=0, hold.
  - in_last accepted in LOAD0 or LOAD1: go to FIN with err set.
  - in_last accepted in LOAD2: set last_seen.
- COEF (1 cycle): op_1=1, clear=1, i<=0, then go to CALC1.
- CALC1 (1 cycle): sel_mult=0, Ld_p1_xi=1, sel_xi2 from i. Then go to CALC2.
- CALC2: sel_mult=1, sel_xi2 from i. Proceed only if the output slot is free (out_valid=0, or out_ready=1 this cycle).
  - When proceeding: Ld_data=1, en_sum=1, out_valid<=1 on the same edge (aligned with data_out).
  - After proceeding: if i<L-1, i<=i+1 and go to CALC1. Else go to FIN if last_seen, otherwise NEXT.
  - When blocked: hold with Ld_data=en_sum=0; p1_xi is retained in the datapath.
- NEXT: in_ready=1. On in_valid: en_stream=1, last_seen<=in_last, go to COEF. Otherwise hold.
- FIN: wait until out_valid=0 (last result consumed), then pulse done=1 and go to IDLE.
- out_valid register: set on Ld_data. Cleared when out_valid&out_ready and no new Ld_data that cycle. Simultaneous consume and load keeps it at 1.
- start while busy is ignored. in_ready is never asserted outside LOAD0-2/NEXT.
- sel_xi2 encoding is fixed: i==0 -> 00, i==1 -> 01, i>=2 -> 10.
- Throughput: 2 cycles per point plus 2 cycles per segment (NEXT+COEF), assuming no stalls.
- Latency: start accepted at cycle 0 with in_valid tied 1 gives LOAD0=c1, LOAD1=c2, LOAD2=c3, COEF=c4, CALC1=c5, CALC2=c6. First out_valid is at c7.
- Counter i is CNT_WIDTH bits and never wraps, because L<=2^CNT_WIDTH-1.

Test Plan:
- Reset with rst=1 mid-CALC2 and out_valid=1 -> next cycle all outputs 0, state IDLE, no done.
- start, L=4, samples 10,20,30(last), in_valid=1, out_ready=1 -> Ld_M0/1/2 on c1-c3; op_1/clear at c4; 4 results with out_valid at c7,c9,c11,c13; sel_xi2 sequence 00,01,10,10; done at c14; err=0.
- L=2, 5 samples (last on 5th), no stalls -> 3 segments, 6 results. en_stream exactly twice. Each segment preceded by op_1+clear.
- Same as above with out_ready held 0 for 5 cycles at the 2nd result -> controller holds in CALC2, no extra Ld_data/en_sum, no result lost or duplicated, sequence resumes.
- in_last on the 2nd sample -> done and err=1 with zero out_valid pulses; a following start clears err.
- l_factor=0 -> behaves as L=1: one result per segment, sel_xi2=00 only. start while busy -> no effect.
